// File: rtl/afifo_read_checker.sv
// Read-side checker for the async FIFO incrementing stream.
// Drains the fall-through port and flags any break in the count sequence.
module afifo_read_checker #(
  parameter int Width      = 12,
  parameter int CountWidth = 16,
  parameter bit StopOnError = 1'b1
) (
  input  logic                  rclk,
  input  logic                  dirclr,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [Width-1:0]      rd,
  output logic                  r,
  output logic                  fail,
  output logic [CountWidth-1:0] wordCount,
  output logic [CountWidth-1:0] errCount,
  output logic [Width-1:0]      errExp,
  output logic [Width-1:0]      errGot,
  output logic                  running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [Width-1:0] expected;
  logic             cons;
  logic             mism;
  logic             r_n;

  // The FIFO advances exactly when our registered request meets a non-empty head.
  assign cons = r & ~rempty;
  assign mism = (state == S_RUN) && (rd != expected);

  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (en) state_n = S_SYNC;
      end
      S_SYNC: begin
        if (!en) state_n = S_IDLE;
        else if (cons) state_n = S_RUN;
      end
      S_RUN: begin
        if (cons && mism && StopOnError) state_n = S_FAIL;
        else if (!en) state_n = S_IDLE;
      end
      S_FAIL: begin
        state_n = S_FAIL;
      end
    endcase
    r_n = (state_n == S_SYNC) || (state_n == S_RUN);
  end

  always_comb begin
    running = (state == S_SYNC) || (state == S_RUN);
  end

  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      r         <= 1'b0;
      fail      <= 1'b0;
      wordCount <= '0;
      errCount  <= '0;
      errExp    <= '0;
      errGot    <= '0;
      expected  <= '0;
    end else begin
      r <= r_n;
      if (cons) begin
        if (wordCount != '1) wordCount <= wordCount + CountWidth'(1);
        if (state == S_SYNC) begin
          expected <= rd + Width'(1);
        end else if (!mism) begin
          expected <= expected + Width'(1);
        end else begin
          if (errCount != '1) errCount <= errCount + CountWidth'(1);
          if (!fail) begin
            errExp <= expected;
            errGot <= rd;
          end
          fail <= 1'b1;
          // Without stop, resync to whatever arrived so one glitch counts once.
          if (!StopOnError) expected <= rd + Width'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_afifo_read_checker.sv
// Directed bench for afifo_read_checker.
// Stop and continue variants share one stimulus bus.
module tb_afifo_read_checker;

  logic        rclk;
  logic        dirclr;
  logic        en;
  logic        rempty;
  logic [11:0] rd;

  logic        r_s, fail_s, run_s;
  logic [15:0] wc_s, ec_s;
  logic [11:0] ee_s, eg_s;
  logic        r_g, fail_g, run_g;
  logic [15:0] wc_g, ec_g;
  logic [11:0] ee_g, eg_g;

  int checks = 0;
  int errors = 0;

  afifo_read_checker #(.StopOnError(1'b1)) dut_stop (
    .rclk(rclk), .dirclr(dirclr), .en(en),
    .rempty(rempty), .rd(rd), .r(r_s),
    .fail(fail_s), .wordCount(wc_s),
    .errCount(ec_s), .errExp(ee_s),
    .errGot(eg_s), .running(run_s)
  );

  afifo_read_checker #(.StopOnError(1'b0)) dut_go (
    .rclk(rclk), .dirclr(dirclr), .en(en),
    .rempty(rempty), .rd(rd), .r(r_g),
    .fail(fail_g), .wordCount(wc_g),
    .errCount(ec_g), .errExp(ee_g),
    .errGot(eg_g), .running(run_g)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    dirclr = 1'b1;
    en     = 1'b0;
    rempty = 1'b1;
    rd     = '0;
    tick();
    dirclr = 1'b0;
  endtask

  // Enable, let IDLE->SYNC raise r, then feed words one per edge.
  task automatic start();
    en     = 1'b1;
    rempty = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [11:0] v);
    rempty = 1'b0;
    rd     = v;
    tick();
    rempty = 1'b1;
  endtask

  int unsigned cnt;
  logic [11:0] cur;

  initial begin
    dirclr = 1'b1;
    en     = 1'b0;
    rempty = 1'b1;
    rd     = '0;
    #2;
    chk("rst_r", r_s, 0);
    chk("rst_fail", fail_s, 0);
    chk("rst_wc", wc_s, 0);
    chk("rst_ec", ec_s, 0);
    chk("rst_ee", ee_s, 0);
    chk("rst_eg", eg_s, 0);
    chk("rst_run", run_s, 0);
    tick();

    // 0x000..0x0FF contiguous
    dirclr = 1'b0;
    en     = 1'b1;
    rempty = 1'b0;
    rd     = '0;
    chk("t1_r_pre", r_s, 0);
    tick();
    chk("t1_r_edge2", r_s, 1);
    chk("t1_wc_pre", wc_s, 0);
    for (int i = 0; i < 256; i++) begin
      rd = 12'(i);
      tick();
    end
    rempty = 1'b1;
    chk("t1_wc", wc_s, 256);
    chk("t1_fail", fail_s, 0);
    chk("t1_ec", ec_s, 0);

    // wrap through 0xFFF
    do_reset();
    start();
    feed(12'hFFD);
    feed(12'hFFE);
    feed(12'hFFF);
    feed(12'h000);
    feed(12'h001);
    chk("t2_fail", fail_s, 0);
    chk("t2_wc", wc_s, 5);
    chk("t2_ec", ec_s, 0);

    // stop on error
    do_reset();
    start();
    feed(12'd5);
    feed(12'd6);
    feed(12'd7);
    chk("t3_fail_pre", fail_s, 0);
    feed(12'd9);
    chk("t3_fail", fail_s, 1);
    chk("t3_ee", ee_s, 12'h008);
    chk("t3_eg", eg_s, 12'h009);
    chk("t3_ec", ec_s, 1);
    chk("t3_wc", wc_s, 4);
    chk("t3_r", r_s, 0);
    chk("t3_run", run_s, 0);
    feed(12'd10);
    feed(12'd11);
    feed(12'd12);
    chk("t3_wc_hold", wc_s, 4);
    chk("t3_r_hold", r_s, 0);

    // continue on error
    do_reset();
    start();
    feed(12'd5);
    feed(12'd6);
    feed(12'd9);
    feed(12'd10);
    feed(12'd3);
    feed(12'd4);
    chk("t4_ec", ec_g, 2);
    chk("t4_ee", ee_g, 12'h007);
    chk("t4_eg", eg_g, 12'h009);
    chk("t4_wc", wc_g, 6);
    chk("t4_r", r_g, 1);
    chk("t4_fail", fail_g, 1);

    // random empty gaps, then pause and restart elsewhere
    do_reset();
    start();
    cnt = 0;
    cur = '0;
    for (int i = 0; i < 5000 && cnt < 1000; i++) begin
      rd     = cur;
      rempty = 1'($urandom_range(0, 1));
      tick();
      if (!rempty) begin
        cnt++;
        cur = cur + 12'd1;
      end
    end
    rempty = 1'b1;
    chk("t5_cnt", cnt, 1000);
    chk("t5_wc", wc_s, 1000);
    en = 1'b0;
    tick();
    rempty = 1'b0;
    rd     = 12'h055;
    tick();
    tick();
    chk("t5_run_off", run_s, 0);
    chk("t5_r_off", r_s, 0);
    chk("t5_wc_off", wc_s, 1000);
    start();
    for (int i = 0; i < 16; i++) feed(12'h100 + 12'(i));
    en = 1'b0;
    tick();
    chk("t5_run_off2", run_s, 0);
    start();
    for (int i = 0; i < 8; i++) feed(12'h200 + 12'(i));
    chk("t5_wc_end", wc_s, 1024);
    chk("t5_ec", ec_s, 0);
    chk("t5_fail", fail_s, 0);
    chk("t5_run", run_s, 1);

    // asynchronous clear mid-run
    do_reset();
    start();
    feed(12'd1);
    feed(12'd2);
    feed(12'd4);
    do_reset();
    start();
    for (int i = 0; i < 10; i++) feed(12'(i));
    chk("t6_wc_pre", wc_s, 10);
    rempty = 1'b0;
    rd     = 12'd10;
    #2;
    dirclr = 1'b1;
    #1;
    chk("t6_r_now", r_s, 0);
    chk("t6_wc_now", wc_s, 0);
    chk("t6_fail_now", fail_s, 0);
    tick();
    chk("t6_wc_edge", wc_s, 0);
    chk("t6_r_edge", r_s, 0);
    chk("t6_run_edge", run_s, 0);
    dirclr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
